seq_detector: RTL and testbench
===============================

// Module: seq_detector
// PURPOSE
//  Parametrised streaming pattern detector: matches a fixed LEN-symbol pattern of SYM_W-bit symbols.
//  Successor to the fixed 2-bit / 3-symbol detector. Adds valid-qualified input, overlap or non-overlap mode,
//  and a saturating match counter. Sits on a symbol stream next to the datapath and flags each completed pattern.
// PARAMETERS
//  SYM_W    2                 symbol width in bits, >=1
//  LEN      3                 pattern length in symbols, >=2
//  PATTERN  {2'd1,2'd2,2'd3}  SYM_W*LEN bits; PATTERN[SYM_W*LEN-1 -: SYM_W] is the first (oldest) symbol
//  OVERLAP  1                 1: matches may share symbols; 0: symbol history restarts after each match
//  CNT_W    8                 match counter width, >=1
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      num carries a symbol this cycle
//  num        in   SYM_W  input symbol
//  ans        out  1      registered match pulse
//  match_cnt  out  CNT_W  saturating count of matches
// BEHAVIOUR
//  - Reset: hist=0, fill=0, ans=0, match_cnt=0. Reset takes priority over every other event in the same cycle.
//  - State:
//    - hist: LEN-1 most recent accepted symbols.
//    - fill: 0..LEN-1, saturating; the number of valid history entries.
//  - Accept: in_valid=1 at posedge. Cycles with in_valid=0 change no state, ans<=0, and do not break a partial match.
//  - hit = in_valid && fill==LEN-1 && {hist,num}==PATTERN.
//  - ans <= hit. Latency: ans is high exactly one cycle after the cycle that accepts the final symbol.
//  - On accept without hit: hist <= {hist,num} (shift in, oldest symbol drops); fill <= min(fill+1, LEN-1).
//  - On hit with OVERLAP=1: shift as above; fill stays LEN-1. Back-to-back matches give consecutive ans pulses.
//  - On hit with OVERLAP=0: fill <= 0. The next match needs LEN fresh symbols.
//  - match_cnt <= match_cnt+1 on hit. It holds at 2^CNT_W-1 and never wraps.
//  - Reset mid-pattern discards the partial history. No match can span a reset.
//  - The detector is purely synchronous: no combinational path from num or in_valid to any output.
// CONFIGURATION
//  - Macro SEQ_DET_CNT_EN.
//  - Defined: match_cnt is implemented as described above.
//  - Undefined: no counter flops exist; match_cnt is tied to 0. ans behaviour is identical in both builds.
// STRUCTURE
//  - Shared package seq_det_pkg:
//    - SEQ_DET_SYM_W_DEF=2, SEQ_DET_LEN_DEF=3, SEQ_DET_PATTERN_DEF.
//    - Function sat_inc(cnt, width) for the saturating increment.
//  - No sub-module. One file containing the history shift register, fill counter, comparator and match counter.
// TESTING
//  - Defaults. Send 1,2,3 on consecutive cycles -> ans=1 only in the cycle after 3 is accepted; match_cnt=1.
//  - Defaults. Send 1,2 then in_valid=0 for 3 cycles, then 3 -> one ans pulse after 3; ans=0 during the gap.
//  - Defaults. Send 1,2, assert reset one cycle, then send 3 -> no ans pulse; match_cnt=0.
//  - PATTERN={2'd1,2'd1}, LEN=2. Send 1,1,1,1:
//    - OVERLAP=1 -> ans high 3 consecutive cycles, match_cnt=3.
//    - OVERLAP=0 -> 2 pulses, match_cnt=2.
//  - CNT_W=2, defaults otherwise. Send 1,2,3 five times -> match_cnt reads 1,2,3,3,3.
//    Without SEQ_DET_CNT_EN -> match_cnt=0 throughout; ans unchanged.
//  - Defaults. Send 2,1,1,2,3 -> exactly one ans pulse, after the final 3.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared definitions for the streaming pattern detector.
// Provides default symbol width, pattern length and pattern, plus the
// saturating increment used by the match counter.
// Counter widths up to 32 bits are supported by sat_inc.
package seq_det_pkg;

  localparam int unsigned SEQ_DET_SYM_W_DEF = 2;
  localparam int unsigned SEQ_DET_LEN_DEF   = 3;
  localparam int unsigned SEQ_DET_PAT_W_DEF = SEQ_DET_SYM_W_DEF * SEQ_DET_LEN_DEF;

  // Oldest symbol in the most significant slot: 1, then 2, then 3.
  localparam logic [SEQ_DET_PAT_W_DEF-1:0] SEQ_DET_PATTERN_DEF = {2'd1, 2'd2, 2'd3};

  localparam int unsigned SEQ_DET_SAT_MAX_W = 32;

  // Increment cnt by one, holding at 2^width-1 instead of wrapping.
  function automatic logic [SEQ_DET_SAT_MAX_W-1:0] sat_inc(
    input logic [SEQ_DET_SAT_MAX_W-1:0] cnt,
    input int unsigned                  width
  );
    logic [SEQ_DET_SAT_MAX_W-1:0] max_val;
    if (width >= SEQ_DET_SAT_MAX_W) begin
      max_val = '1;
    end else begin
      max_val = (SEQ_DET_SAT_MAX_W'(1) << width) - SEQ_DET_SAT_MAX_W'(1);
    end
    if (cnt >= max_val) begin
      return max_val;
    end
    return cnt + SEQ_DET_SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/seq_detector.sv
// Streaming pattern detector: flags each occurrence of a fixed LEN-symbol
// pattern in a valid-qualified symbol stream.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   in_valid   num carries a symbol this cycle
//   num        input symbol (SYM_W bits)
//   ans        registered one-cycle match pulse
//   match_cnt  saturating match count (CNT_W bits)
//
// Build option: define SEQ_DET_CNT_EN to implement the match counter;
// without it no counter flops exist and match_cnt is tied to zero.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned            SYM_W   = SEQ_DET_SYM_W_DEF,
  parameter int unsigned            LEN     = SEQ_DET_LEN_DEF,
  parameter logic [SYM_W*LEN-1:0]   PATTERN = SEQ_DET_PATTERN_DEF,
  parameter bit                     OVERLAP = 1'b1,
  parameter int unsigned            CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] num,
  output logic             ans,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned HIST_W = SYM_W * (LEN - 1);
  localparam int unsigned WIN_W  = SYM_W * LEN;
  localparam int unsigned FILL_W = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN - 1);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              ans_q, ans_d;
  logic [WIN_W-1:0]  win_c;
  logic              hit_c;

  // Candidate window: stored history followed by the incoming symbol.
  assign win_c = {hist_q, num};
  assign hit_c = in_valid && (fill_q == FILL_FULL) && (win_c == PATTERN);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      ans_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      ans_q  <= ans_d;
    end
  end

  // Next-state: idle cycles hold history so a partial match survives gaps.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    ans_d  = 1'b0;
    if (in_valid) begin
      hist_d = win_c[HIST_W-1:0];
      ans_d  = hit_c;
      if (hit_c && !OVERLAP) begin
        // Non-overlapping: the next match must be built from fresh symbols.
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  assign ans = ans_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hit_c) begin
      cnt_d = CNT_W'(sat_inc(SEQ_DET_SAT_MAX_W'(cnt_q), CNT_W));
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector. Four instances share one stimulus bus:
// default config, LEN=2 pattern 1,1 overlapping and non-overlapping, and a
// 2-bit counter variant. Inputs change on negedge; outputs are sampled 1ns
// after each posedge.
module tb_seq_detector;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [1:0] num;

  logic       ans_def, ans_ov, ans_nov, ans_c2;
  logic [7:0] cnt_def, cnt_ov, cnt_nov;
  logic [1:0] cnt_c2;

  int unsigned n_vec;
  int unsigned n_err;

  seq_detector #(.CNT_W(8)) dut_def (
    .clk(clk), .reset(reset), .in_valid(in_valid), .num(num),
    .ans(ans_def), .match_cnt(cnt_def)
  );

  seq_detector #(.SYM_W(2), .LEN(2), .PATTERN(4'b0101), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .clk(clk), .reset(reset), .in_valid(in_valid), .num(num),
    .ans(ans_ov), .match_cnt(cnt_ov)
  );

  seq_detector #(.SYM_W(2), .LEN(2), .PATTERN(4'b0101), .OVERLAP(1'b0), .CNT_W(8)) dut_nov (
    .clk(clk), .reset(reset), .in_valid(in_valid), .num(num),
    .ans(ans_nov), .match_cnt(cnt_nov)
  );

  seq_detector #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .num(num),
    .ans(ans_c2), .match_cnt(cnt_c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value depends on whether the counter is built.
  function automatic logic [31:0] ecnt(input int unsigned v);
`ifdef SEQ_DET_CNT_EN
    return 32'(v);
`else
    return 32'(v & 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus; returns with outputs settled after the edge.
  task automatic step(input logic rst, input logic iv, input logic [1:0] n);
    @(negedge clk);
    reset    = rst;
    in_valid = iv;
    num      = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'd0);
  endtask

  initial begin
    logic [1:0] seq5 [5];
    logic       exp5 [5];
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    num      = 2'd0;

    // Reset state.
    do_reset();
    chk("rst_ans", 32'(ans_def), 32'd0);
    chk("rst_cnt", 32'(cnt_def), 32'd0);

    // Consecutive 1,2,3: pulse only after the 3.
    step(1'b0, 1'b1, 2'd1);
    chk("b2b_ans1", 32'(ans_def), 32'd0);
    step(1'b0, 1'b1, 2'd2);
    chk("b2b_ans2", 32'(ans_def), 32'd0);
    step(1'b0, 1'b1, 2'd3);
    chk("b2b_ans3", 32'(ans_def), 32'd1);
    chk("b2b_cnt", 32'(cnt_def), ecnt(1));
    step(1'b0, 1'b0, 2'd0);
    chk("b2b_after", 32'(ans_def), 32'd0);

    // Gap of three invalid cycles does not break the partial match.
    do_reset();
    step(1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd3);
      chk($sformatf("gap_idle%0d", i), 32'(ans_def), 32'd0);
    end
    step(1'b0, 1'b1, 2'd3);
    chk("gap_ans", 32'(ans_def), 32'd1);
    chk("gap_cnt", 32'(cnt_def), ecnt(1));
    step(1'b0, 1'b0, 2'd0);
    chk("gap_after", 32'(ans_def), 32'd0);

    // Reset mid-pattern discards history.
    do_reset();
    step(1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b1, 2'd2);
    do_reset();
    step(1'b0, 1'b1, 2'd3);
    chk("rmid_ans", 32'(ans_def), 32'd0);
    chk("rmid_cnt", 32'(cnt_def), 32'd0);

    // LEN=2 pattern 1,1 fed 1,1,1,1: overlap vs non-overlap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'd1);
      chk($sformatf("ov_ans%0d", i), 32'(ans_ov), (i >= 1) ? 32'd1 : 32'd0);
      chk($sformatf("nov_ans%0d", i), 32'(ans_nov), (i == 1 || i == 3) ? 32'd1 : 32'd0);
    end
    chk("ov_cnt", 32'(cnt_ov), ecnt(3));
    chk("nov_cnt", 32'(cnt_nov), ecnt(2));

    // 1,2,3 five times: 2-bit counter saturates at 3, 8-bit keeps counting.
    do_reset();
    for (int r = 1; r <= 5; r++) begin
      step(1'b0, 1'b1, 2'd1);
      step(1'b0, 1'b1, 2'd2);
      step(1'b0, 1'b1, 2'd3);
      chk($sformatf("sat_ans%0d", r), 32'(ans_c2), 32'd1);
      chk($sformatf("sat_cnt%0d", r), 32'(cnt_c2), ecnt((r > 3) ? 3 : r));
      chk($sformatf("def_cnt%0d", r), 32'(cnt_def), ecnt(r));
    end

    // 2,1,1,2,3: single pulse after the final 3.
    do_reset();
    seq5[0] = 2'd2; seq5[1] = 2'd1; seq5[2] = 2'd1; seq5[3] = 2'd2; seq5[4] = 2'd3;
    exp5[0] = 1'b0; exp5[1] = 1'b0; exp5[2] = 1'b0; exp5[3] = 1'b0; exp5[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, seq5[i]);
      chk($sformatf("mix_ans%0d", i), 32'(ans_def), 32'(exp5[i]));
    end
    chk("mix_cnt", 32'(cnt_def), ecnt(1));
    step(1'b0, 1'b0, 2'd0);
    chk("mix_after", 32'(ans_def), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
